// File: rtl/pc_pkg.sv
// Shared op encoding and priority encoder for the PC / return-stack slice.
// Imported by pc_stack and ras_lifo.
package pc_pkg;

    localparam logic [2:0] OP_HOLD = 3'd0;
    localparam logic [2:0] OP_INC  = 3'd1;
    localparam logic [2:0] OP_LOAD = 3'd2;
    localparam logic [2:0] OP_CALL = 3'd3;
    localparam logic [2:0] OP_RET  = 3'd4;

    // ret > call > load > inc > hold
    function automatic logic [2:0] pc_op(
        input logic ret,
        input logic call,
        input logic load,
        input logic inc
    );
        logic [2:0] op;
        op = OP_HOLD;
        priority case (1'b1)
            ret:     op = OP_RET;
            call:    op = OP_CALL;
            load:    op = OP_LOAD;
            inc:     op = OP_INC;
            default: op = OP_HOLD;
        endcase
        return op;
    endfunction

endpackage

// File: rtl/ras_lifo.sv
// Circular return-address LIFO: storage, stack pointer, depth count.
// Ports: clock, reset (async low), push, pop, wdata, rdata, full, empty, depth.
module ras_lifo
    import pc_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int DEPTH = 8
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wdata,
    output logic [WIDTH-1:0]         rdata,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   depth
);

    localparam int PW = $clog2(DEPTH);
    localparam logic [PW-1:0] SP_ONE  = PW'(1);
    localparam logic [PW:0]   CNT_ONE = (PW+1)'(1);
    localparam logic [PW:0]   CNT_MAX = (PW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    sp;
    logic [PW:0]      cnt;

    assign full  = (cnt == CNT_MAX);
    assign empty = (cnt == '0);
    assign depth = cnt;
    assign rdata = mem[sp - SP_ONE];

    // A push while full wraps sp onto the oldest entry; count saturates.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            sp  <= '0;
            cnt <= '0;
        end else if (push) begin
            sp <= sp + SP_ONE;
            if (!full)
                cnt <= cnt + CNT_ONE;
        end else if (pop && !empty) begin
            sp  <= sp - SP_ONE;
            cnt <= cnt - CNT_ONE;
        end
    end

    // Contents are don't-care after reset, so no reset here.
    always_ff @(posedge clock) begin
        if (push)
            mem[sp] <= wdata;
    end

endmodule

// File: rtl/pc_stack.sv
// Fetch program counter with hardware return-address stack.
// Ports: clock, reset (async low), in, load, inc, call, ret, rel -> out, depth, ovf, unf.
// Optional: define PC_REL_BRANCH_EN for pc-relative load/call targets.
module pc_stack
    import pc_pkg::*;
#(
    parameter int               WIDTH     = 16,
    parameter int               DEPTH     = 8,
    parameter logic [WIDTH-1:0] RESET_VEC = '0
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         in,
    input  logic                     load,
    input  logic                     inc,
    input  logic                     call,
    input  logic                     ret,
    input  logic                     rel,
    output logic [WIDTH-1:0]         out,
    output logic [$clog2(DEPTH):0]   depth,
    output logic                     ovf,
    output logic                     unf
);

    logic [2:0]       op;
    logic [WIDTH-1:0] pc_inc;
    logic [WIDTH-1:0] target;
    logic [WIDTH-1:0] top;
    logic [WIDTH-1:0] pc_next;
    logic             push;
    logic             pop;
    logic             full;
    logic             empty;

    assign op     = pc_op(ret, call, load, inc);
    assign push   = (op == OP_CALL);
    assign pop    = (op == OP_RET);
    assign pc_inc = out + WIDTH'(1);

`ifdef PC_REL_BRANCH_EN
    // in is a two's-complement offset; mod-2^WIDTH add handles the sign.
    assign target = rel ? (out + in) : in;
`else
    logic unused_rel;
    assign unused_rel = rel;
    assign target     = in;
`endif

    ras_lifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_ras (
        .clock (clock),
        .reset (reset),
        .push  (push),
        .pop   (pop),
        .wdata (pc_inc),
        .rdata (top),
        .full  (full),
        .empty (empty),
        .depth (depth)
    );

    always_comb begin
        pc_next = out;
        case (op)
            OP_INC:  pc_next = pc_inc;
            OP_LOAD: pc_next = target;
            OP_CALL: pc_next = target;
            OP_RET:  if (!empty) pc_next = top;
            default: pc_next = out;
        endcase
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            out <= RESET_VEC;
            ovf <= 1'b0;
            unf <= 1'b0;
        end else begin
            out <= pc_next;
            if (push && full)
                ovf <= 1'b1;
            if (pop && empty)
                unf <= 1'b1;
        end
    end

endmodule

// File: tb/tb_pc_stack.sv
// Randomised + directed scoreboard bench for pc_stack.
// Model keeps return addresses in a bounded queue.
module tb_pc_stack;

    localparam int WIDTH = 16;
    localparam int DEPTH = 8;

    logic             clock;
    logic             reset;
    logic [WIDTH-1:0] in;
    logic             load, inc, call, ret, rel;
    logic [WIDTH-1:0] out;
    logic [3:0]       depth;
    logic             ovf, unf;

    pc_stack #(
        .WIDTH     (WIDTH),
        .DEPTH     (DEPTH),
        .RESET_VEC (16'h0000)
    ) dut (
        .clock (clock),
        .reset (reset),
        .in    (in),
        .load  (load),
        .inc   (inc),
        .call  (call),
        .ret   (ret),
        .rel   (rel),
        .out   (out),
        .depth (depth),
        .ovf   (ovf),
        .unf   (unf)
    );

    typedef struct {
        logic [15:0] out;
        logic [3:0]  depth;
        logic        ovf;
        logic        unf;
    } exp_t;

    exp_t        sb[$];
    logic [15:0] stk[$];
    logic [15:0] m_out;
    logic        m_ovf, m_unf;
    int          n_cmp = 0;
    int          n_bad = 0;

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic chk_state(input string nm, input exp_t e);
        chk({nm, ".out"},   32'(out),   32'(e.out));
        chk({nm, ".depth"}, 32'(depth), 32'(e.depth));
        chk({nm, ".ovf"},   32'(ovf),   32'(e.ovf));
        chk({nm, ".unf"},   32'(unf),   32'(e.unf));
    endtask

    function automatic exp_t model_now();
        exp_t e;
        e.out   = m_out;
        e.depth = 4'(stk.size());
        e.ovf   = m_ovf;
        e.unf   = m_unf;
        return e;
    endfunction

    task automatic model_reset();
        m_out = 16'h0000;
        m_ovf = 1'b0;
        m_unf = 1'b0;
        stk.delete();
    endtask

    // Drive one cycle of inputs and queue the state expected after the edge.
    task automatic step(input logic [15:0] i, input logic l, input logic n,
                        input logic c, input logic r, input logic rl);
        logic [15:0] tgt;
        logic [15:0] drop;
        @(negedge clock);
        in = i; load = l; inc = n; call = c; ret = r; rel = rl;
`ifdef PC_REL_BRANCH_EN
        tgt = rl ? 16'(m_out + i) : i;
`else
        tgt = i;
`endif
        if (r) begin
            if (stk.size() > 0) m_out = stk.pop_back();
            else m_unf = 1'b1;
        end else if (c) begin
            if (stk.size() == DEPTH) begin
                drop  = stk.pop_front();
                m_ovf = 1'b1;
            end
            stk.push_back(16'(m_out + 16'd1));
            m_out = tgt;
        end else if (l) begin
            m_out = tgt;
        end else if (n) begin
            m_out = 16'(m_out + 16'd1);
        end
        sb.push_back(model_now());
    endtask

    // Reset asserted away from any edge must clear outputs at once.
    task automatic mid_reset();
        exp_t z;
        @(posedge clock);
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        z = model_now();
        chk_state("rst_async", z);
        @(negedge clock);
        in = '0; load = 0; inc = 0; call = 0; ret = 0; rel = 0;
        @(posedge clock);
        #1;
        chk_state("rst_hold", z);
        @(negedge clock);
        reset = 1'b1;
    endtask

    // Monitor: the DUT presents a new state every edge.
    initial begin
        exp_t e;
        forever begin
            @(posedge clock);
            #1;
            if (sb.size() > 0) begin
                e = sb.pop_front();
                chk_state("sb", e);
            end
        end
    end

    initial begin
        reset = 1'b0;
        in = '0; load = 0; inc = 0; call = 0; ret = 0; rel = 0;
        model_reset();
        #3;
        chk_state("reset", model_now());
        @(negedge clock);
        reset = 1'b1;

        repeat (3) step(16'h0, 0, 1, 0, 0, 0);
        step(16'h0, 0, 1, 0, 0, 0);
        mid_reset();

        step(16'hFFFF, 1, 0, 0, 0, 0);
        step(16'h0000, 0, 1, 0, 0, 0);

        step(16'h0010, 1, 0, 0, 0, 0);
        step(16'h0100, 0, 0, 1, 0, 0);
        step(16'h0200, 0, 0, 1, 0, 0);
        step(16'h0000, 0, 0, 0, 1, 0);
        step(16'h0000, 0, 0, 0, 1, 0);

        step(16'h0041, 1, 0, 0, 0, 0);
        step(16'h0080, 0, 0, 1, 0, 0);
        step(16'h1234, 1, 1, 1, 1, 0);
        step(16'h0007, 1, 1, 0, 0, 0);

        for (int k = 0; k < DEPTH + 1; k++)
            step(16'(16'h1000 + k * 16), 0, 0, 1, 0, 0);
        for (int k = 0; k < DEPTH + 1; k++)
            step(16'h0000, 0, 0, 0, 1, 0);
        step(16'h0300, 1, 0, 0, 0, 0);
        step(16'h0000, 0, 1, 0, 0, 0);

        step(16'h0100, 1, 0, 0, 0, 0);
        step(16'hFFF0, 1, 0, 0, 0, 1);
        step(16'h0010, 0, 0, 1, 0, 1);
        step(16'h0000, 0, 0, 0, 1, 0);

        mid_reset();

        for (int k = 0; k < 400; k++)
            step(16'($urandom),
                 ($urandom % 4) == 0,
                 ($urandom % 2) == 0,
                 ($urandom % 4) == 0,
                 ($urandom % 5) == 0,
                 ($urandom % 2) == 0);

        @(negedge clock);
        in = '0; load = 0; inc = 0; call = 0; ret = 0; rel = 0;
        repeat (3) @(posedge clock);
        #2;
        chk("drain", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/pc_stack.md
Name: pc_stack

Overview:
- Parametrised program counter for the CPU fetch path, and the successor to the fixed 16-bit in/load/inc/reset counter.
- Adds a hardware return-address stack (call/return), configurable width, depth and reset vector, and sticky stack-error flags.
- Sits between the control unit and instruction-memory address port; `out` drives the fetch address directly.

Parameters:
- WIDTH, 16, PC and data width in bits (>=4)
- DEPTH, 8, return-stack entries (power of 2, >=2)
- RESET_VEC, 0, value loaded into `out` on reset (WIDTH bits)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- in  in  WIDTH  jump/call target (or offset, see Optional Feature)
- load  in  1  jump: out <= in
- inc  in  1  increment: out <= out+1
- call  in  1  push out+1, then out <= in
- ret  in  1  pop: out <= top of stack
- rel  in  1  relative-jump select (see Optional Feature)
- out  out  WIDTH  current PC, registered
- depth  out  $clog2(DEPTH)+1  number of valid stack entries
- ovf  out  1  sticky: call issued while stack full
- unf  out  1  sticky: ret issued while stack empty

Behaviour:
- Reset, asynchronous and active-low:
  - out=RESET_VEC, depth=0, ovf=0, unf=0, stack pointer=0.
  - Stack contents are don't-care.
  - Reset asserted mid-operation discards any pending op immediately.
- All other updates occur on the rising clock edge. Outputs are registered and visible one cycle after the controlling inputs are sampled.
- Priority, highest first, one op per cycle: ret > call > load > inc > hold. Lower-priority inputs are ignored in the same cycle.
- inc: out <= out+1 modulo 2^WIDTH. All-ones wraps to 0.
- load: out <= in.
- call:
  - Write (out+1) mod 2^WIDTH to stack[sp], sp <= sp+1, out <= in.
  - When depth==DEPTH: write overwrites the oldest entry (circular), depth stays DEPTH, ovf <= 1.
  - out <= in still happens when full.
- ret:
  - depth>0: out <= stack[sp-1], sp <= sp-1, depth <= depth-1.
  - depth==0: out holds, sp and depth unchanged, unf <= 1.
- The stack pointer is circular modulo DEPTH. After overflow, DEPTH returns succeed and yield the newest DEPTH addresses; the next ret underflows.
- ovf and unf clear only on reset.
- No combinational path from inputs to out.

Optional Feature:
- Macro: PC_REL_BRANCH_EN.
- Defined:
  - When load=1 and rel=1 (and no ret/call), out <= (out + in) mod 2^WIDTH, with `in` interpreted as two's complement.
  - When call=1 and rel=1, the target is out+in and the pushed value is still out+1.
- Undefined: `rel` is present but ignored. load and call always use absolute `in`. No adder is synthesised beyond the incrementer.

Decomposition:
- Shared package pc_pkg:
  - op encoding localparams OP_HOLD, OP_INC, OP_LOAD, OP_CALL, OP_RET.
  - a priority-encode function mapping (ret, call, load, inc) to op.
- Sub-module ras_lifo (parameters WIDTH, DEPTH):
  - owns the storage array, circular pointer, depth counter, full and empty.
  - ports: push, pop, wdata, rdata, full, empty, depth.
- pc_stack holds the out register, next-PC mux and sticky flags.

Test Plan:
- Reset then inc: release reset with RESET_VEC=0; inc for 3 cycles -> out 0,1,2,3. Assert reset low mid-inc -> out=0 immediately, without waiting for a clock edge.
- Wrap: load in=16'hFFFF, then inc -> out=16'h0000, ovf=0.
- Nested call/return:
  - At out=16'h0010, call in=16'h0100 -> out=16'h0100, depth=1.
  - Then call in=16'h0200 -> out=16'h0200, depth=2.
  - ret -> out=16'h0101; ret -> out=16'h0011, depth=0.
- Priority: ret=1, call=1, load=1, inc=1 with depth=1 holding 16'h0042 -> out=16'h0042, no push. Then load=1, inc=1, in=16'h0007 -> out=16'h0007.
- Boundaries:
  - With DEPTH=8, issue 9 calls -> ovf=1, depth=8; 8 rets return the 8 newest return addresses.
  - A 9th ret -> out holds, unf=1.
  - ovf and unf stay 1 until reset.
- With PC_REL_BRANCH_EN defined: out=16'h0100, load=1, rel=1, in=16'hFFF0 -> out=16'h00F0. Without the macro, the same stimulus -> out=16'hFFF0.
